pipeline_hazard_ctrl: RTL and testbench

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

---
 rtl/pipeline_hazard_ctrl.sv | 157 +++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard, flush and data-memory stall control for a 5-stage pipeline, with saturating perf counters.
// Build option: define HAZARD_FORWARD_EN when a forwarding unit exists, so only load-use has to stall.
module pipeline_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_memread,
    input  logic             ex_regwrite,
    input  logic [4:0]       ex_rd,
    input  logic             mem_regwrite,
    input  logic [4:0]       mem_rd,
    input  logic             ex_branch_taken,
    input  logic             ex_jump,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             pipe_freeze,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count,
    output logic [1:0]       fsm_state
);

    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_MEM_WAIT = 2'd1;
    localparam logic [1:0] ST_HALT     = 2'd2;

    localparam int              WAIT_W     = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);

    logic [1:0]        state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              mem_timeout_q, mem_timeout_d;
    logic [CNT_W-1:0]  stall_q, stall_d;
    logic [CNT_W-1:0]  flush_q, flush_d;

    logic [WAIT_W-1:0] wait_inc;
    logic              ex_load_hit;
    logic              hazard;
    logic              run_rules;

    // A load always writes its destination, so ex_memread stands in for its write flag.
    function automatic logic reg_match(input logic [4:0] rd, input logic wr);
        return wr && (rd != 5'd0) && ((rd == id_rs) || (id_uses_rt && (rd == id_rt)));
    endfunction

    assign ex_load_hit = reg_match(ex_rd, ex_memread);

`ifdef HAZARD_FORWARD_EN
    logic unused_fwd_inputs;
    assign unused_fwd_inputs = ^{ex_regwrite, mem_regwrite, mem_rd};
    assign hazard = ex_load_hit;
`else
    assign hazard = ex_load_hit || reg_match(ex_rd, ex_regwrite) || reg_match(mem_rd, mem_regwrite);
`endif

    assign wait_inc = wait_q + WAIT_W'(1);

    always_comb begin
        state_d       = state_q;
        wait_d        = wait_q;
        mem_timeout_d = mem_timeout_q;
        pc_write      = 1'b1;
        ifid_write    = 1'b1;
        ifid_flush    = 1'b0;
        idex_bubble   = 1'b0;
        pipe_freeze   = 1'b0;
        run_rules     = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (dmem_req && !dmem_ready) begin
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    pipe_freeze = 1'b1;
                    wait_d      = '0;
                    state_d     = ST_MEM_WAIT;
                end else begin
                    run_rules = 1'b1;
                end
            end
            ST_MEM_WAIT: begin
                if (dmem_ready) begin
                    run_rules = 1'b1;
                    state_d   = ST_RUN;
                end else begin
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    pipe_freeze = 1'b1;
                    wait_d      = wait_inc;
                    if (wait_inc == WAIT_LIMIT) begin
                        mem_timeout_d = 1'b1;
                        state_d       = ST_HALT;
                    end
                end
            end
            ST_HALT: begin
                pc_write    = 1'b0;
                ifid_write  = 1'b0;
                pipe_freeze = 1'b1;
            end
            default: state_d = ST_RUN;
        endcase

        // Control transfer wins over load-use: the stalled instruction is being squashed anyway.
        if (run_rules) begin
            if (ex_branch_taken || ex_jump) begin
                ifid_flush  = 1'b1;
                idex_bubble = 1'b1;
            end else if (hazard) begin
                pc_write    = 1'b0;
                ifid_write  = 1'b0;
                idex_bubble = 1'b1;
            end
        end

        stall_d = stall_q;
        flush_d = flush_q;
        if (!pc_write && (stall_q != '1)) stall_d = stall_q + CNT_W'(1);
        if (ifid_flush && (flush_q != '1)) flush_d = flush_q + CNT_W'(1);

        if (rst) begin
            state_d       = ST_RUN;
            wait_d        = '0;
            mem_timeout_d = 1'b0;
            stall_d       = '0;
            flush_d       = '0;
            pc_write      = 1'b0;
            ifid_write    = 1'b0;
            ifid_flush    = 1'b1;
            idex_bubble   = 1'b1;
            pipe_freeze   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        state_q       <= state_d;
        wait_q        <= wait_d;
        mem_timeout_q <= mem_timeout_d;
        stall_q       <= stall_d;
        flush_q       <= flush_d;
    end

    assign mem_timeout  = mem_timeout_q;
    assign stall_cycles = stall_q;
    assign flush_count  = flush_q;
    assign fsm_state    = state_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Randomized and directed bench for pipeline_hazard_ctrl; expected outputs come from a cycle model.
module tb_pipeline_hazard_ctrl;

    localparam int TB_CNT_W  = 4;
    localparam int TB_TMO    = 15;
    localparam int CNT_MAX   = (1 << TB_CNT_W) - 1;
    localparam int EXP_W     = 8 + 2 * TB_CNT_W;

    typedef struct packed {
        logic       rst;
        logic [4:0] id_rs;
        logic [4:0] id_rt;
        logic       uses_rt;
        logic       ex_memread;
        logic       ex_regwrite;
        logic [4:0] ex_rd;
        logic       mem_regwrite;
        logic [4:0] mem_rd;
        logic       br;
        logic       jmp;
        logic       req;
        logic       rdy;
    } stim_t;

    logic                clk;
    logic                rst;
    logic [4:0]          id_rs, id_rt, ex_rd, mem_rd;
    logic                id_uses_rt, ex_memread, ex_regwrite, mem_regwrite;
    logic                ex_branch_taken, ex_jump, dmem_req, dmem_ready;
    logic                pc_write, ifid_write, ifid_flush, idex_bubble, pipe_freeze, mem_timeout;
    logic [TB_CNT_W-1:0] stall_cycles, flush_count;
    logic [1:0]          fsm_state;

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(TB_TMO), .CNT_W(TB_CNT_W)) dut (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_memread(ex_memread), .ex_regwrite(ex_regwrite), .ex_rd(ex_rd),
        .mem_regwrite(mem_regwrite), .mem_rd(mem_rd),
        .ex_branch_taken(ex_branch_taken), .ex_jump(ex_jump),
        .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
        .idex_bubble(idex_bubble), .pipe_freeze(pipe_freeze), .mem_timeout(mem_timeout),
        .stall_cycles(stall_cycles), .flush_count(flush_count), .fsm_state(fsm_state)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // scoreboard state
    logic [EXP_W-1:0] exp_q[$];
    int checks   = 0;
    int failures = 0;
    int cycle_no = 0;
    bit drive_done = 0;

    // reference model: mode 0=RUN 1=MEM_WAIT 2=HALT
    int m_mode, m_wait, m_stall, m_flush;
    bit m_tmo;

    function automatic bit m_match(input logic [4:0] rd, input bit flag, input stim_t s);
        return flag && (rd != 0) && ((rd == s.id_rs) || (s.uses_rt && (rd == s.id_rt)));
    endfunction

    function automatic bit m_hazard(input stim_t s);
        bit h;
        h = m_match(s.ex_rd, s.ex_memread, s);
`ifndef HAZARD_FORWARD_EN
        h = h || m_match(s.ex_rd, s.ex_regwrite, s) || m_match(s.mem_rd, s.mem_regwrite, s);
`endif
        return h;
    endfunction

    function automatic stim_t idle();
        stim_t s;
        s = '0;
        return s;
    endfunction

    task automatic drive(input stim_t s);
        bit pc, ifw, fl, bub, frz, rules;
        int nmode;
        @(negedge clk);
        rst = s.rst; id_rs = s.id_rs; id_rt = s.id_rt; id_uses_rt = s.uses_rt;
        ex_memread = s.ex_memread; ex_regwrite = s.ex_regwrite; ex_rd = s.ex_rd;
        mem_regwrite = s.mem_regwrite; mem_rd = s.mem_rd;
        ex_branch_taken = s.br; ex_jump = s.jmp; dmem_req = s.req; dmem_ready = s.rdy;

        if (s.rst) begin
            exp_q.push_back({2'(m_mode), 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, m_tmo,
                             TB_CNT_W'(m_stall), TB_CNT_W'(m_flush)});
            m_mode = 0; m_wait = 0; m_tmo = 0; m_stall = 0; m_flush = 0;
            return;
        end

        pc = 1; ifw = 1; fl = 0; bub = 0; frz = 0; rules = 0; nmode = m_mode;
        if (m_mode == 2 || (m_mode == 0 && s.req && !s.rdy) || (m_mode == 1 && !s.rdy)) begin
            pc = 0; ifw = 0; frz = 1;
        end else begin
            rules = 1;
        end
        if (rules) begin
            if (s.br || s.jmp) begin
                fl = 1; bub = 1;
            end else if (m_hazard(s)) begin
                pc = 0; ifw = 0; bub = 1;
            end
        end
        exp_q.push_back({2'(m_mode), pc, ifw, fl, bub, frz, m_tmo,
                         TB_CNT_W'(m_stall), TB_CNT_W'(m_flush)});

        if (m_mode == 0 && frz) begin
            nmode = 1; m_wait = 0;
        end else if (m_mode == 1) begin
            if (s.rdy) nmode = 0;
            else begin
                m_wait++;
                if (m_wait >= TB_TMO) begin nmode = 2; m_tmo = 1; end
            end
        end
        m_mode = nmode;
        if (!pc) m_stall = (m_stall < CNT_MAX) ? m_stall + 1 : CNT_MAX;
        if (fl)  m_flush = (m_flush < CNT_MAX) ? m_flush + 1 : CNT_MAX;
    endtask

    // monitor: every cycle the DUT presents a fresh output word
    initial begin
        logic [EXP_W-1:0] got, exp;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                exp = exp_q.pop_front();
                got = {fsm_state, pc_write, ifid_write, ifid_flush, idex_bubble, pipe_freeze,
                       mem_timeout, stall_cycles, flush_count};
                checks++;
                if (got !== exp) begin
                    failures++;
                    $display("FAIL cycle%0d outputs {st,pc,ifw,fl,bub,frz,tmo,stall,flush}: got=%b expected=%b",
                             cycle_no, got, exp);
                end
                cycle_no++;
            end
        end
    end

    // stimulus
    initial begin
        stim_t s;
        int burst;
        rst = 1'b1; id_rs = '0; id_rt = '0; id_uses_rt = 0; ex_memread = 0; ex_regwrite = 0;
        ex_rd = '0; mem_regwrite = 0; mem_rd = '0; ex_branch_taken = 0; ex_jump = 0;
        dmem_req = 0; dmem_ready = 0;
        m_mode = 0; m_wait = 0; m_tmo = 0; m_stall = 0; m_flush = 0;
        repeat (2) @(posedge clk);

        s = idle(); s.rst = 1; drive(s); drive(s);
        s = idle(); drive(s);

        // load-use, then load to r0
        s = idle(); s.ex_memread = 1; s.ex_regwrite = 1; s.ex_rd = 8; s.id_rs = 8; drive(s);
        s.ex_rd = 0; s.id_rs = 0; drive(s);
        // branch together with load-use
        s = idle(); s.ex_memread = 1; s.ex_rd = 8; s.id_rs = 8; s.br = 1; drive(s);
        // memory stall with a branch held in EX
        s = idle(); s.br = 1; s.req = 1; s.rdy = 0;
        repeat (3) drive(s);
        s.rdy = 1; drive(s);
        s = idle(); drive(s);
        // non-load dependencies through EX then MEM
        s = idle(); s.ex_regwrite = 1; s.ex_rd = 5; s.id_rt = 5; s.uses_rt = 1; drive(s);
        s = idle(); s.mem_regwrite = 1; s.mem_rd = 5; s.id_rt = 5; s.uses_rt = 1; drive(s);
        s.uses_rt = 0; drive(s);
        // timeout into HALT, then reset
        s = idle(); s.req = 1; s.rdy = 0;
        repeat (16) drive(s);
        s.rdy = 1; s.br = 1; repeat (3) drive(s);
        s = idle(); s.rst = 1; drive(s);
        s = idle(); drive(s);
        // flush counter saturation
        s = idle(); s.jmp = 1; repeat (20) drive(s);
        // ready arrives on the last allowed wait cycle
        s = idle(); s.req = 1; s.rdy = 0; repeat (15) drive(s);
        s.rdy = 1; drive(s);
        s = idle(); s.rst = 1; drive(s);

        burst = 0;
        for (int i = 0; i < 3000; i++) begin
            s = idle();
            s.rst = ($urandom_range(0, 99) == 0);
            s.id_rs = 5'($urandom_range(0, 3));
            s.id_rt = 5'($urandom_range(0, 3));
            s.uses_rt = 1'($urandom_range(0, 1));
            s.ex_memread = ($urandom_range(0, 3) == 0);
            s.ex_regwrite = 1'($urandom_range(0, 1));
            s.ex_rd = 5'($urandom_range(0, 3));
            s.mem_regwrite = 1'($urandom_range(0, 1));
            s.mem_rd = 5'($urandom_range(0, 3));
            s.br = ($urandom_range(0, 7) == 0);
            s.jmp = ($urandom_range(0, 15) == 0);
            s.req = ($urandom_range(0, 5) == 0);
            if (burst == 0 && $urandom_range(0, 39) == 0) burst = $urandom_range(5, 20);
            if (burst > 0) begin
                s.rdy = 0; s.req = 1; burst--;
            end else begin
                s.rdy = ($urandom_range(0, 3) != 0);
            end
            drive(s);
        end

        @(negedge clk);
        #4;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
